// File: rtl/fft_mag_writer.sv
// Producer side of the FFT-magnitude BRAM handshake: turns the complex FFT stream into
// per-bin magnitude estimates, writes one frame into BRAM port A, then holds it for the consumer.
//
// state    | meaning
// ---------+------------------------------------------------------------------
// ST_SYNC  | discard samples until a frame boundary (fft_last) is seen
// ST_ARM   | aligned; next valid sample is bin 0 of a new frame
// ST_CAPTURE| storing bins, checking fft_last against the sample count
// ST_DRAIN | frame complete, waiting for the magnitude pipeline to empty
// ST_HOLD  | frame owned by consumer; incoming frames dropped until consumer_done
module fft_mag_writer #(
   parameter int NFFT   = 2048,
   parameter int ADDR_W = 10,
   parameter int DATA_W = 16
) (
   input  logic                     i_clock,
   input  logic                     i_reset,
   input  logic signed [DATA_W-1:0] i_fft_re,
   input  logic signed [DATA_W-1:0] i_fft_im,
   input  logic                     i_fft_valid,
   input  logic                     i_fft_last,
   input  logic                     i_consumer_done,
   output logic                     o_bram_we,
   output logic [ADDR_W-1:0]        o_bram_addr,
   output logic [DATA_W-1:0]        o_bram_din,
   output logic                     o_done,
   output logic [7:0]               o_frames_dropped,
   output logic                     o_sync_err
);

   localparam int CNT_W = $clog2(NFFT);

   typedef enum logic [2:0] {
      ST_SYNC,
      ST_ARM,
      ST_CAPTURE,
      ST_DRAIN,
      ST_HOLD
   } state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_in_frame;

   logic               r_s1_vld;
   logic [DATA_W:0]    r_s1_a;
   logic [DATA_W:0]    r_s1_b;
   logic [ADDR_W-1:0]  r_s1_addr;
   logic               r_s2_vld;
   logic [DATA_W:0]    r_s2_mx;
   logic [DATA_W:0]    r_s2_mn;
   logic [ADDR_W-1:0]  r_s2_addr;

   logic               w_capturing;
   logic [CNT_W-1:0]   w_idx;
   logic               w_in_range;
   logic               w_push;
   logic               w_at_end;
   logic [DATA_W:0]    w_re_ext;
   logic [DATA_W:0]    w_im_ext;
   logic [DATA_W:0]    w_abs_re;
   logic [DATA_W:0]    w_abs_im;
   logic [DATA_W+1:0]  w_sum;
   logic [DATA_W-1:0]  w_mag;

   // In ARM the counter is not yet meaningful; the accepted sample is bin 0 by definition.
   assign w_capturing = i_fft_valid && (r_state == ST_ARM || r_state == ST_CAPTURE);
   assign w_idx       = (r_state == ST_ARM) ? '0 : r_cnt;
   assign w_at_end    = (w_idx == CNT_W'(NFFT - 1));

   generate
      if (CNT_W > ADDR_W) begin : g_range
         assign w_in_range = ~|w_idx[CNT_W-1:ADDR_W];
      end else begin : g_all
         assign w_in_range = 1'b1;
      end
   endgenerate

   assign w_push = w_capturing && w_in_range;

   // One extra bit so that -2**(DATA_W-1) has an exact magnitude.
   assign w_re_ext = {i_fft_re[DATA_W-1], i_fft_re};
   assign w_im_ext = {i_fft_im[DATA_W-1], i_fft_im};
   assign w_abs_re = w_re_ext[DATA_W] ? (~w_re_ext + (DATA_W+1)'(1)) : w_re_ext;
   assign w_abs_im = w_im_ext[DATA_W] ? (~w_im_ext + (DATA_W+1)'(1)) : w_im_ext;

   assign w_sum = {1'b0, r_s2_mx} + {2'b00, r_s2_mn[DATA_W:1]};
   assign w_mag = (|w_sum[DATA_W+1:DATA_W]) ? '1 : w_sum[DATA_W-1:0];

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_s1_vld    <= 1'b0;
         r_s1_a      <= '0;
         r_s1_b      <= '0;
         r_s1_addr   <= '0;
         r_s2_vld    <= 1'b0;
         r_s2_mx     <= '0;
         r_s2_mn     <= '0;
         r_s2_addr   <= '0;
         o_bram_we   <= 1'b0;
         o_bram_addr <= '0;
         o_bram_din  <= '0;
      end else begin
         r_s1_vld <= w_push;
         if (w_push) begin
            r_s1_a    <= w_abs_re;
            r_s1_b    <= w_abs_im;
            r_s1_addr <= w_idx[ADDR_W-1:0];
         end
         r_s2_vld <= r_s1_vld;
         if (r_s1_vld) begin
            r_s2_mx   <= (r_s1_a >= r_s1_b) ? r_s1_a : r_s1_b;
            r_s2_mn   <= (r_s1_a >= r_s1_b) ? r_s1_b : r_s1_a;
            r_s2_addr <= r_s1_addr;
         end
         o_bram_we <= r_s2_vld;
         if (r_s2_vld) begin
            o_bram_addr <= r_s2_addr;
            o_bram_din  <= w_mag;
         end
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state          <= ST_SYNC;
         r_cnt            <= '0;
         r_in_frame       <= 1'b0;
         o_done           <= 1'b0;
         o_frames_dropped <= '0;
         o_sync_err       <= 1'b0;
      end else begin
         o_done <= 1'b0;

         // Frames arriving while the BRAM is owned elsewhere are tracked for the exit decision.
         if ((r_state == ST_DRAIN || r_state == ST_HOLD) && i_fft_valid) begin
            r_in_frame <= !i_fft_last;
            if (i_fft_last && o_frames_dropped != 8'hFF)
               o_frames_dropped <= o_frames_dropped + 8'd1;
         end

         case (r_state)
            ST_SYNC: begin
               if (i_fft_valid && i_fft_last)
                  r_state <= ST_ARM;
            end
            ST_ARM, ST_CAPTURE: begin
               if (i_fft_valid) begin
                  if (i_fft_last && w_at_end) begin
                     r_cnt      <= '0;
                     r_in_frame <= 1'b0;
                     r_state    <= ST_DRAIN;
                  end else if (i_fft_last) begin
                     r_cnt      <= '0;
                     o_sync_err <= 1'b1;
                     r_state    <= ST_ARM;
                  end else if (w_at_end) begin
                     r_cnt      <= '0;
                     o_sync_err <= 1'b1;
                     r_state    <= ST_SYNC;
                  end else begin
                     r_cnt   <= w_idx + CNT_W'(1);
                     r_state <= ST_CAPTURE;
                  end
               end
            end
            ST_DRAIN: begin
               if (!r_s1_vld && !r_s2_vld) begin
                  o_done  <= 1'b1;
                  r_state <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (i_consumer_done) begin
                  if (i_fft_valid && i_fft_last)
                     r_state <= ST_ARM;
                  else if (r_in_frame || i_fft_valid)
                     r_state <= ST_SYNC;
                  else
                     r_state <= ST_ARM;
               end
            end
            default: r_state <= ST_SYNC;
         endcase
      end
   end

endmodule
